// File: rtl/wb_dual_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_dual_arbiter
// Description : Writeback stage between the even/odd execute pipes and the
//               register file. It registers both pipe results and drives the
//               file's two write ports (ep/op).
//               In a dual-issue pair the even result is older and the odd
//               result is younger. When both write the same RT, the odd
//               result must land last. In that case the odd result is parked
//               for one cycle in a skid register, and both pipes are stalled
//               while it is parked.
// Ports       : clock / reset (async, active-low)
//               ep_valid, ep_rt_addr, ep_rt_value   even pipe result in
//               op_valid, op_rt_addr, op_rt_value   odd pipe result in
//               wb_stall                            upstream hold request
//               wrt_en_ep, rt_ep_address, rt_value_ep  even write port
//               wrt_en_op, rt_op_address, rt_value_op  odd write port
//               conflict_cnt                        same-RT collision count
// Config      : `define WB_CONFLICT_CNT_EN to build the saturating collision
//               counter. Without it, conflict_cnt is tied to zero.
// Revision    : 1.0  initial release
// ============================================================================
module wb_dual_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ep_valid,
    input  logic [ADDR_W-1:0] ep_rt_addr,
    input  logic [DATA_W-1:0] ep_rt_value,
    input  logic              op_valid,
    input  logic [ADDR_W-1:0] op_rt_addr,
    input  logic [DATA_W-1:0] op_rt_value,
    output logic              wb_stall,
    output logic              wrt_en_ep,
    output logic [ADDR_W-1:0] rt_ep_address,
    output logic [DATA_W-1:0] rt_value_ep,
    output logic              wrt_en_op,
    output logic [ADDR_W-1:0] rt_op_address,
    output logic [DATA_W-1:0] rt_value_op,
    output logic [31:0]       conflict_cnt
);

    // The state register is the skid-full flag. HOLD means an odd result is parked.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [ADDR_W-1:0]   r_skid_addr;
    logic [DATA_W-1:0]   r_skid_value;
    logic [ADDR_W-1:0]   w_skid_addr_next;
    logic [DATA_W-1:0]   w_skid_value_next;

    logic                r_en_ep;
    logic [ADDR_W-1:0]   r_ep_addr;
    logic [DATA_W-1:0]   r_ep_value;
    logic                r_en_op;
    logic [ADDR_W-1:0]   r_op_addr;
    logic [DATA_W-1:0]   r_op_value;

    logic                w_en_ep_next;
    logic [ADDR_W-1:0]   w_ep_addr_next;
    logic [DATA_W-1:0]   w_ep_value_next;
    logic                w_en_op_next;
    logic [ADDR_W-1:0]   w_op_addr_next;
    logic [DATA_W-1:0]   w_op_value_next;

    logic                w_collision;
    logic                w_park;

    assign w_collision = ep_valid & op_valid & (ep_rt_addr == op_rt_addr);
    // An IDLE->HOLD transition happens exactly when a collision is sampled in IDLE.
    assign w_park      = (r_state == ST_IDLE) & w_collision;

    // Stall comes straight from the skid-full flop, so no input reaches it combinationally.
    assign wb_stall    = (r_state == ST_HOLD);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_en_ep_next      = 1'b0;
        w_en_op_next      = 1'b0;
        // Address and data hold their last value unless a write is issued.
        w_ep_addr_next    = r_ep_addr;
        w_ep_value_next   = r_ep_value;
        w_op_addr_next    = r_op_addr;
        w_op_value_next   = r_op_value;
        w_skid_addr_next  = r_skid_addr;
        w_skid_value_next = r_skid_value;

        case (r_state)
            ST_IDLE: begin
                w_en_ep_next = ep_valid;
                if (ep_valid) begin
                    w_ep_addr_next  = ep_rt_addr;
                    w_ep_value_next = ep_rt_value;
                end
                if (w_collision) begin
                    // The younger odd result is parked so that it is written after the even one.
                    w_skid_addr_next  = op_rt_addr;
                    w_skid_value_next = op_rt_value;
                    w_state_next      = ST_HOLD;
                end else begin
                    w_en_op_next = op_valid;
                    if (op_valid) begin
                        w_op_addr_next  = op_rt_addr;
                        w_op_value_next = op_rt_value;
                    end
                end
            end
            ST_HOLD: begin
                // Pipe inputs are held upstream and ignored here. Drain the skid.
                // Returning to IDLE empties the skid, because the state is the full flag.
                w_en_op_next    = 1'b1;
                w_op_addr_next  = r_skid_addr;
                w_op_value_next = r_skid_value;
                w_state_next    = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Write-port and skid registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_en_ep      <= 1'b0;
            r_ep_addr    <= '0;
            r_ep_value   <= '0;
            r_en_op      <= 1'b0;
            r_op_addr    <= '0;
            r_op_value   <= '0;
            r_skid_addr  <= '0;
            r_skid_value <= '0;
        end else begin
            r_en_ep      <= w_en_ep_next;
            r_ep_addr    <= w_ep_addr_next;
            r_ep_value   <= w_ep_value_next;
            r_en_op      <= w_en_op_next;
            r_op_addr    <= w_op_addr_next;
            r_op_value   <= w_op_value_next;
            r_skid_addr  <= w_skid_addr_next;
            r_skid_value <= w_skid_value_next;
        end
    end

    assign wrt_en_ep     = r_en_ep;
    assign rt_ep_address = r_ep_addr;
    assign rt_value_ep   = r_ep_value;
    assign wrt_en_op     = r_en_op;
    assign rt_op_address = r_op_addr;
    assign rt_value_op   = r_op_value;

    // ------------------------------------------------------------------------
    // Optional collision counter. It saturates instead of wrapping.
    // ------------------------------------------------------------------------
`ifdef WB_CONFLICT_CNT_EN
    logic [31:0] r_conflict_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_conflict_cnt <= '0;
        end else if (w_park && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`else
    assign conflict_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_dual_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_dual_arbiter
// Description : Self-checking bench for wb_dual_arbiter. A table of vectors
//               covers the single-cycle cases. Hand-written sequences cover
//               the stall, back-to-back and reset corner cases.
//               Expected writes are queued with their expected cycle when the
//               inputs are accepted, and popped as the DUT writes.
// Revision    : 1.0  initial release
// ============================================================================
module tb_wb_dual_arbiter;

    localparam int AW = 7;
    localparam int DW = 128;

    logic          clock = 1'b0;
    logic          reset;
    logic          ep_valid;
    logic [AW-1:0] ep_rt_addr;
    logic [DW-1:0] ep_rt_value;
    logic          op_valid;
    logic [AW-1:0] op_rt_addr;
    logic [DW-1:0] op_rt_value;
    logic          wb_stall;
    logic          wrt_en_ep;
    logic [AW-1:0] rt_ep_address;
    logic [DW-1:0] rt_value_ep;
    logic          wrt_en_op;
    logic [AW-1:0] rt_op_address;
    logic [DW-1:0] rt_value_op;
    logic [31:0]   conflict_cnt;

    wb_dual_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock         (clock),
        .reset         (reset),
        .ep_valid      (ep_valid),
        .ep_rt_addr    (ep_rt_addr),
        .ep_rt_value   (ep_rt_value),
        .op_valid      (op_valid),
        .op_rt_addr    (op_rt_addr),
        .op_rt_value   (op_rt_value),
        .wb_stall      (wb_stall),
        .wrt_en_ep     (wrt_en_ep),
        .rt_ep_address (rt_ep_address),
        .rt_value_ep   (rt_value_ep),
        .wrt_en_op     (wrt_en_op),
        .rt_op_address (rt_op_address),
        .rt_value_op   (rt_value_op),
        .conflict_cnt  (conflict_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit            port;   // 0 = even, 1 = odd
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    typedef struct {
        logic          ev;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ov;
        logic [AW-1:0] oa;
        logic [DW-1:0] od;
        logic          exp_stall;
    } vec_t;

    wr_t           sbq[$];
    vec_t          vecs[8];
    logic [DW-1:0] rf[128];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            n_writes = 0;
    logic          m_stall = 1'b0;
    logic [31:0]   m_cnt   = '0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic ev, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                         input logic ov, input logic [AW-1:0] oa, input logic [DW-1:0] od);
        ep_valid    = ev;
        ep_rt_addr  = ea;
        ep_rt_value = ed;
        op_valid    = ov;
        op_rt_addr  = oa;
        op_rt_value = od;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic check_port(input bit port, input logic en,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        if (en) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: port %0d wrote addr %0d, required no write (cycle %0d)",
                         port, a, cyc);
            end else begin
                e = sbq.pop_front();
                chk("wr_port",  DW'(port), DW'(e.port));
                chk("wr_addr",  DW'(a),    DW'(e.addr));
                chk("wr_data",  d,         e.data);
                chk("wr_cycle", DW'(cyc),  DW'(e.cyc));
            end
            rf[a] = d;
            n_writes++;
        end
    endtask

    // One clock: the model accepts the inputs if it is not stalled, then the outputs are checked after the edge.
    task automatic tick();
        wr_t  e;
        logic coll;
        logic m_next;
        m_next = 1'b0;
        if (!m_stall) begin
            coll = ep_valid & op_valid & (ep_rt_addr == op_rt_addr);
            if (ep_valid) begin
                e.port = 1'b0; e.addr = ep_rt_addr; e.data = ep_rt_value; e.cyc = cyc + 1;
                sbq.push_back(e);
            end
            if (op_valid) begin
                e.port = 1'b1; e.addr = op_rt_addr; e.data = op_rt_value;
                e.cyc  = coll ? cyc + 2 : cyc + 1;
                sbq.push_back(e);
            end
            m_next = coll;
            if (coll && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
        @(posedge clock);
        #1;
        cyc++;
        m_stall = m_next;
        chk("wb_stall", DW'(wb_stall), DW'(m_stall));
        check_port(1'b0, wrt_en_ep, rt_ep_address, rt_value_ep);
        check_port(1'b1, wrt_en_op, rt_op_address, rt_value_op);
        if (wrt_en_ep && wrt_en_op)
            chk("same_addr_both_ports", DW'(rt_ep_address == rt_op_address), DW'(1'b0));
`ifdef WB_CONFLICT_CNT_EN
        chk("conflict_cnt", DW'(conflict_cnt), DW'(m_cnt));
`else
        chk("conflict_cnt", DW'(conflict_cnt), DW'(32'd0));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"},   DW'(wb_stall),      '0);
        chk({tag, "_en_ep"},   DW'(wrt_en_ep),     '0);
        chk({tag, "_addr_ep"}, DW'(rt_ep_address), '0);
        chk({tag, "_val_ep"},  rt_value_ep,        '0);
        chk({tag, "_en_op"},   DW'(wrt_en_op),     '0);
        chk({tag, "_addr_op"}, DW'(rt_op_address), '0);
        chk({tag, "_val_op"},  rt_value_op,        '0);
        chk({tag, "_cnt"},     DW'(conflict_cnt),  '0);
    endtask

    localparam logic [DW-1:0] VA = {4{32'hAAAA_0001}};
    localparam logic [DW-1:0] VB = {4{32'hBBBB_0002}};
    localparam logic [DW-1:0] VC = {4{32'hCCCC_0003}};
    localparam logic [DW-1:0] VD = {4{32'hDDDD_0004}};
    localparam logic [DW-1:0] VE = {4{32'hEEEE_0005}};
    localparam logic [DW-1:0] VF = {4{32'hFFFF_0006}};
    localparam logic [DW-1:0] VG = {4{32'h1234_5678}};
    localparam logic [DW-1:0] VH = {4{32'h8765_4321}};

    initial begin
        int w0;
        for (int i = 0; i < 128; i++) rf[i] = '0;
        reset = 1'b0;
        idle();

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b1;

        // Table vectors, each applied from IDLE. exp_stall is the stall seen one cycle later.
        vecs[0] = '{1'b1, 7'd5,   VA, 1'b1, 7'd9,   VB, 1'b0};  // no collision
        vecs[1] = '{1'b1, 7'd12,  VA, 1'b1, 7'd12,  VB, 1'b1};  // collision
        vecs[2] = '{1'b1, 7'd7,   VC, 1'b0, 7'd7,   VD, 1'b0};  // single even valid
        vecs[3] = '{1'b0, 7'd7,   VE, 1'b1, 7'd7,   VF, 1'b0};  // single odd valid
        vecs[4] = '{1'b0, 7'd3,   VE, 1'b0, 7'd3,   VF, 1'b0};  // nothing valid
        vecs[5] = '{1'b1, 7'd0,   VC, 1'b1, 7'd0,   VD, 1'b1};  // register 0 collides too
        vecs[6] = '{1'b1, 7'd127, VE, 1'b1, 7'd126, VF, 1'b0};
        vecs[7] = '{1'b1, 7'd127, VG, 1'b1, 7'd127, VH, 1'b1};
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].ev, vecs[i].ea, vecs[i].ed, vecs[i].ov, vecs[i].oa, vecs[i].od);
            tick();
            chk("vec_stall", DW'(wb_stall), DW'(vecs[i].exp_stall));
            if (vecs[i].exp_stall) tick();
        end
        idle();
        repeat (2) tick();
        chk("rf_12_odd_last",  rf[12],  VB);
        chk("rf_0_odd_last",   rf[0],   VD);
        chk("rf_127_odd_last", rf[127], VH);
        chk("rf_126",          rf[126], VF);
        chk("rf_7_odd_single", rf[7],   VF);

        // Inputs changed during the stall must be ignored.
        drive(1'b1, 7'd20, VC, 1'b1, 7'd20, VD);
        tick();
        drive(1'b1, 7'd40, VG, 1'b1, 7'd41, VH);
        tick();
        drive(1'b1, 7'd30, VE, 1'b1, 7'd31, VF);
        tick();
        idle();
        repeat (2) tick();
        chk("rf_20", rf[20], VD);
        chk("rf_30", rf[30], VE);
        chk("rf_31", rf[31], VF);
        chk("rf_40_untouched", rf[40], '0);
        chk("rf_41_untouched", rf[41], '0);

        // Three back-to-back colliding pairs, each held through its stall.
        w0 = n_writes;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, AW'(50 + i), VA ^ DW'(i), 1'b1, AW'(50 + i), VB ^ DW'(i));
            tick();
            tick();
        end
        idle();
        repeat (2) tick();
        chk("b2b_write_count", DW'(n_writes - w0), DW'(6));
        for (int i = 0; i < 3; i++) chk("b2b_rf", rf[50 + i], VB ^ DW'(i));
`ifdef WB_CONFLICT_CNT_EN
        chk("conflict_total", DW'(conflict_cnt), DW'(32'd7));
`else
        chk("conflict_absent", DW'(conflict_cnt), DW'(32'd0));
`endif

        // Asynchronous reset while the odd result is parked.
        drive(1'b1, 7'd60, VC, 1'b1, 7'd60, VD);
        tick();
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midhold");
        sbq.delete();
        m_stall = 1'b0;
        m_cnt   = '0;
        idle();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) tick();
        chk("rf_60_even_only", rf[60], VC);

        chk("scoreboard_drained", DW'(sbq.size()), DW'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
